// File: rtl/vram_scanline_fetcher.sv
// Streams one scanline of 32-bit VRAM words through a prefetch FIFO and serialises them to pixels.
// Optional VRAM_FETCH_4BPP_EN adds mode_4bpp_i for two zero-extended nibble pixels per byte.
module vram_scanline_fetcher #(
  parameter int unsigned LINE_WORDS = 80,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_reset_i,
  input  logic        line_start_i,
  input  logic [14:0] line_addr_i,
`ifdef VRAM_FETCH_4BPP_EN
  input  logic        mode_4bpp_i,
`endif
  output logic        busy_o,
  output logic [14:0] vram_addr_o,
  input  logic [31:0] vram_data_i,
  output logic [7:0]  pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        line_done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [15:0] LastIssue = 16'(LINE_WORDS);
  localparam logic [17:0] Px8 = 18'(4 * LINE_WORDS);
  localparam logic [17:0] Px4 = 18'(8 * LINE_WORDS);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            r_state;
  logic [14:0]       r_vram_addr;
  logic [15:0]       r_issue_cnt;
  logic [1:0]        r_inflight;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_fifo_cnt;
  logic [31:0]       r_word;
  logic [2:0]        r_sub;
  logic [7:0]        r_pix_data;
  logic              r_pix_valid;
  logic [17:0]       r_pix_cnt;
  logic              r_busy;

  logic              w_mode, w_fire, w_last_sub, w_pop, w_push, w_issue, w_line_done;
  logic [1:0]        w_inflight_n;
  logic [OccW-1:0]   w_occ;
  logic [17:0]       w_total;
  logic [7:0]        w_head_pix, w_next_pix;

`ifdef VRAM_FETCH_4BPP_EN
  logic r_mode;
  assign w_mode = r_mode;
`else
  assign w_mode = 1'b0;
`endif

  function automatic logic [7:0] pick_pix(input logic [31:0] word, input logic [2:0] idx,
                                          input logic mode);
    if (mode) pick_pix = {4'h0, word[{idx, 2'b00} +: 4]};
    else      pick_pix = word[{idx[1:0], 3'b000} +: 8];
  endfunction

  always_comb begin
    w_fire       = r_pix_valid && pix_ready_i;
    w_last_sub   = w_mode ? (r_sub == 3'd7) : (r_sub == 3'd3);
    w_pop        = (!r_pix_valid || (w_fire && w_last_sub)) && (r_fifo_cnt != '0);
    w_push       = r_inflight[1];
    w_inflight_n = {1'b0, r_inflight[1]} + {1'b0, r_inflight[0]};
    w_occ        = OccW'(r_fifo_cnt) + OccW'(w_inflight_n);
    // Counting in-flight reads against free space is what keeps the FIFO from overflowing.
    w_issue      = (r_state == StFetch) && (r_issue_cnt != LastIssue) &&
                   (w_occ < OccW'(FIFO_DEPTH));
    w_total      = w_mode ? Px4 : Px8;
    w_line_done  = (r_state == StDrain) && w_fire && (r_pix_cnt == w_total - 18'd1) &&
                   (r_fifo_cnt == '0) && (r_inflight == 2'b00);
    w_head_pix   = pick_pix(r_fifo[r_rd_ptr], 3'd0, w_mode);
    w_next_pix   = pick_pix(r_word, r_sub + 3'd1, w_mode);
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= vram_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      r_state     <= StIdle;
      r_vram_addr <= '0;
      r_issue_cnt <= '0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_word      <= '0;
      r_sub       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_cnt   <= '0;
      r_busy      <= 1'b0;
`ifdef VRAM_FETCH_4BPP_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      r_inflight <= {r_inflight[0], 1'b0};
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;

      if (w_pop) begin
        r_word      <= r_fifo[r_rd_ptr];
        r_sub       <= '0;
        r_pix_data  <= w_head_pix;
        r_pix_valid <= 1'b1;
      end else if (w_fire && w_last_sub) begin
        r_pix_valid <= 1'b0;
      end else if (w_fire) begin
        r_sub      <= r_sub + 3'd1;
        r_pix_data <= w_next_pix;
      end
      if (w_fire) r_pix_cnt <= r_pix_cnt + 18'd1;

      unique case (r_state)
        StIdle: begin
          if (line_start_i) begin
            // Latching the start address is itself the first read of the line.
            r_vram_addr <= line_addr_i;
            r_issue_cnt <= 16'd1;
            r_inflight  <= {r_inflight[0], 1'b1};
            r_sub       <= '0;
            r_pix_cnt   <= '0;
            r_busy      <= 1'b1;
`ifdef VRAM_FETCH_4BPP_EN
            r_mode      <= mode_4bpp_i;
`endif
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          if (w_issue) begin
            r_vram_addr <= r_vram_addr + 15'd1;
            r_issue_cnt <= r_issue_cnt + 16'd1;
            r_inflight  <= {r_inflight[0], 1'b1};
          end
          if (r_issue_cnt == LastIssue) r_state <= StDrain;
        end
        StDrain: begin
          if (w_line_done) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign vram_addr_o = r_vram_addr;
  assign pix_data_o  = r_pix_data;
  assign pix_valid_o = r_pix_valid;
  assign line_done_o = w_line_done;

endmodule

// File: tb/tb_vram_scanline_fetcher.sv
// Randomised bench: VRAM memory model plus an expected-pixel queue built from word order and byte lanes.
module tb_vram_scanline_fetcher;
  localparam int unsigned LW = 4;
  localparam int unsigned FD = 4;

  logic        clk = 1'b0;
  logic        rst, line_start, ready;
  logic [14:0] line_addr;
  logic        busy, pix_valid, line_done;
  logic [14:0] vram_addr;
  logic [31:0] vram_data;
  logic [7:0]  pix_data;
  logic [31:0] mem [32768];

  int          n_cmp = 0, n_err = 0;
  int          n_done = 0, n_lines = 0, px_line = 0, ahead;
  logic [7:0]  exp_q [$];
  logic [7:0]  e_pix, prev_data;
  logic [14:0] base, ad;
  bit          mon_en = 1'b0, prev_stall = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) vram_data <= mem[vram_addr];

  vram_scanline_fetcher #(.LINE_WORDS(LW), .FIFO_DEPTH(FD)) u_dut (
    .wb_clk_i     (clk),
    .wb_reset_i   (rst),
    .line_start_i (line_start),
    .line_addr_i  (line_addr),
`ifdef VRAM_FETCH_4BPP_EN
    .mode_4bpp_i  (1'b0),
`endif
    .busy_o       (busy),
    .vram_addr_o  (vram_addr),
    .vram_data_i  (vram_data),
    .pix_data_o   (pix_data),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (ready),
    .line_done_o  (line_done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pixel monitor: order, line_done placement, hold-while-stalled, prefetch distance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_valid && ready) begin
        if (exp_q.size() == 0) chk("extra_pix", 1, 0);
        else begin
          e_pix = exp_q.pop_front();
          chk("pix", {24'h0, pix_data}, {24'h0, e_pix});
          chk("done_pos", {31'h0, line_done}, (exp_q.size() == 0) ? 1 : 0);
        end
        if (busy) begin
          ad    = vram_addr - base;
          ahead = int'(ad) + 1 - px_line / 4;
          chk("ahead", (ahead <= int'(FD) + 1) ? 1 : 0, 1);
        end
        px_line++;
      end else if (line_done) begin
        chk("done_spur", 1, 0);
      end
      if (line_done) n_done++;
      if (prev_stall) begin
        chk("hold_v", {31'h0, pix_valid}, 1);
        chk("hold_d", {24'h0, pix_data}, {24'h0, prev_data});
      end
      prev_stall = pix_valid && !ready;
      prev_data  = pix_data;
    end
  end

  task automatic run_line(input logic [14:0] a, input int stall, input bit tp, input bit ign);
    logic [31:0] word;
    logic [14:0] wa;
    int first, dcyc, d0, cyc;
    for (int w = 0; w < int'(LW); w++) begin
      wa   = a + 15'(w);
      word = mem[wa];
      for (int b = 0; b < 4; b++) exp_q.push_back(word[8*b +: 8]);
    end
    base    = a;
    px_line = 0;
    n_lines++;
    d0      = n_done;
    first   = -1;
    dcyc    = -1;
    @(posedge clk); #1;
    line_addr  = a;
    line_start = 1'b1;
    ready      = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
    @(posedge clk); #1;
    line_start = 1'b0;
    for (cyc = 1; cyc < 3000 && dcyc < 0; cyc++) begin
      ready      = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
      line_addr  = 15'($urandom);
      line_start = ign && (cyc == 6);
      @(negedge clk); #1;
      if (first < 0 && pix_valid) first = cyc;
      if (n_done != d0) dcyc = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    if (dcyc < 0) begin
      chk("timeout", 0, 1);
      exp_q.delete();
    end else begin
      chk("latency", (first >= 1 && first <= 4) ? 1 : 0, 1);
      if (tp) chk("thruput", 32'(dcyc - first), 4 * LW - 1);
      chk("q_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("busy_drop", {31'h0, busy}, 0);
      chk("one_done", 32'(n_done - d0), 1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    ready      = 1'b0;
    line_addr  = '0;
    for (int i = 0; i < 32768; i++) mem[i] = $urandom;
    mem[15'h0100] = 32'h0302_0100;
    mem[15'h0101] = 32'h0706_0504;
    mem[15'h0102] = 32'h0b0a_0908;
    mem[15'h0103] = 32'h0f0e_0d0c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_valid", {31'h0, pix_valid}, 0);
    chk("rst_done", {31'h0, line_done}, 0);
    chk("rst_addr", {17'h0, vram_addr}, 0);
    chk("rst_data", {24'h0, pix_data}, 0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    run_line(15'h0100, 0, 1'b1, 1'b0);
    for (int l = 0; l < 4; l++) run_line(15'($urandom), 30, 1'b0, 1'b0);
    run_line(15'h7FFE, 30, 1'b0, 1'b0);
    chk("wrap_addr", {17'h0, vram_addr}, 32'h0001);
    run_line(15'h2345, 30, 1'b0, 1'b1);

    // Reset with reads in flight and words buffered: nothing stale may surface.
    mon_en = 1'b0;
    ready  = 1'b0;
    @(posedge clk); #1;
    line_addr  = 15'h4000;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {31'h0, pix_valid}, 0);
    chk("mrst_busy", {31'h0, busy}, 0);
    chk("mrst_addr", {17'h0, vram_addr}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mrst_quiet", {31'h0, pix_valid}, 0);
    end

    // Reset and line_start together: reset wins.
    @(posedge clk); #1;
    rst        = 1'b1;
    line_start = 1'b1;
    line_addr  = 15'h1234;
    @(posedge clk); #1;
    rst        = 1'b0;
    line_start = 1'b0;
    @(negedge clk);
    chk("rst_win_busy", {31'h0, busy}, 0);
    chk("rst_win_addr", {17'h0, vram_addr}, 0);
    prev_stall = 1'b0;
    mon_en     = 1'b1;

    run_line(15'h4000, 30, 1'b0, 1'b0);
    run_line(15'h0100, 0, 1'b1, 1'b0);
    chk("lines", n_done, n_lines);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
